// File: rtl/ram_io_if.sv
// Bus between the memory controller and the RAM/IO responder,
// including the TX byte stream towards the downstream sink.
interface ram_io_if;
  logic [31:0] ram_address_in;
  logic [7:0]  ram_data_in;
  logic        ram_wr_in;
  logic [7:0]  ram_data_out;
  logic        io_full_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic        io_overflow_out;
  logic        sim_end_out;

  modport master (
    output ram_address_in, ram_data_in, ram_wr_in, tx_ready_in,
    input  ram_data_out, io_full_out, tx_data_out, tx_valid_out,
           io_overflow_out, sim_end_out
  );

  modport slave (
    input  ram_address_in, ram_data_in, ram_wr_in, tx_ready_in,
    output ram_data_out, io_full_out, tx_data_out, tx_valid_out,
           io_overflow_out, sim_end_out
  );
endinterface

// File: rtl/ram_io_responder.sv
// Byte-wide RAM with 1-cycle registered reads, plus a memory-mapped IO page
// holding a TX FIFO (0x30000), a FIFO count / halt register (0x30004).
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic     clk_in,
  input  logic     rst_in,
  ram_io_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [17:0]      TX_ADDR   = 18'h30000;
  localparam logic [17:0]      HALT_ADDR = 18'h30004;

  logic [7:0]       mem_r  [2**ADDR_WIDTH];
  logic [7:0]       fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [7:0]       rdata_r;
  logic [7:0]       rdata_next_s;
  logic             valid_r;
  logic             full_r;
  logic             overflow_r;
  logic             sim_end_r;

  logic                  is_io_s;
  logic                  ram_wr_s;
  logic                  tx_wr_s;
  logic                  halt_wr_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;
  logic [ADDR_WIDTH-1:0] ram_idx_s;
  logic                  unused_addr_s;

  // Only the low 18 address bits take part in decoding.
  assign unused_addr_s = ^bus.ram_address_in[31:18];
  assign ram_idx_s     = bus.ram_address_in[ADDR_WIDTH-1:0];

  // Address decode, FIFO push/pop arbitration and next read byte.
  always_comb begin
    is_io_s   = (bus.ram_address_in[17:16] == 2'b11);
    ram_wr_s  = bus.ram_wr_in && !is_io_s;
    tx_wr_s   = bus.ram_wr_in && is_io_s && (bus.ram_address_in[17:0] == TX_ADDR);
    halt_wr_s = bus.ram_wr_in && is_io_s && (bus.ram_address_in[17:0] == HALT_ADDR);
    pop_s     = (count_r != {CNT_W{1'b0}}) && bus.tx_ready_in;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push_s    = tx_wr_s && ((count_r < DEPTH_C) || pop_s);
    drop_s    = tx_wr_s && !push_s;

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1'b1);
      2'b01:   count_next_s = count_r - CNT_W'(1'b1);
      default: count_next_s = count_r;
    endcase

    if (bus.ram_wr_in) begin
      rdata_next_s = rdata_r;
    end else if (!is_io_s) begin
      rdata_next_s = mem_r[ram_idx_s];
    end else if (bus.ram_address_in[17:0] == HALT_ADDR) begin
      rdata_next_s = {{(8-CNT_W){1'b0}}, count_r};
    end else begin
      rdata_next_s = 8'h00;
    end
  end

  // RAM and FIFO storage arrays; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (ram_wr_s) begin
      mem_r[ram_idx_s] <= bus.ram_data_in;
    end
    if (push_s) begin
      fifo_r[wr_ptr_r] <= bus.ram_data_in;
    end
  end

  // FIFO pointers, count and the flags decoded from the next count.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {CNT_W{1'b0}});
      full_r  <= (count_next_s == DEPTH_C);
    end
  end

  // Read data register and sticky status flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdata_r    <= 8'h00;
      overflow_r <= 1'b0;
      sim_end_r  <= 1'b0;
    end else begin
      rdata_r <= rdata_next_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (halt_wr_s) begin
        sim_end_r <= 1'b1;
      end
    end
  end

  assign bus.ram_data_out    = rdata_r;
  assign bus.io_full_out     = full_r;
  assign bus.tx_data_out     = fifo_r[rd_ptr_r];
  assign bus.tx_valid_out    = valid_r;
  assign bus.io_overflow_out = overflow_r;
  assign bus.sim_end_out     = sim_end_r;
endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: RAM vector table, then FIFO,
// halt-register and asynchronous-reset sequences against a small model.
module tb_ram_io_responder;
  logic clk_in;
  logic rst_in;
  ram_io_if bus ();

  ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        wr;
    logic [7:0]  exp_rd;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fq [$];
  logic [7:0] rd_q [$];
  logic [7:0] ram_m [logic [16:0]];
  logic [7:0] last_rd = 8'h00;
  logic       ovf_m   = 1'b0;
  logic       end_m   = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle; exp_rd < 0 means the model supplies the read byte.
  task automatic step(input logic [31:0] addr, input logic [7:0] wd, input logic wr,
                      input logic rdy, input int exp_rd);
    logic       io;
    logic [7:0] e;
    bus.ram_address_in = addr;
    bus.ram_data_in    = wd;
    bus.ram_wr_in      = wr;
    bus.tx_ready_in    = rdy;
    #1;
    io = (addr[17:16] == 2'b11);
    if (exp_rd >= 0)                    e = exp_rd[7:0];
    else if (wr)                        e = last_rd;
    else if (!io)                       e = ram_m[addr[16:0]];
    else if (addr[17:0] == 18'h30004)   e = 8'(fq.size());
    else                                e = 8'h00;
    last_rd = e;
    rd_q.push_back(e);
    if (rdy && fq.size() != 0) begin
      chk("tx_data", bus.tx_data_out, fq[0]);
      void'(fq.pop_front());
    end
    if (wr && !io) ram_m[addr[16:0]] = wd;
    if (wr && io && addr[17:0] == 18'h30000) begin
      if (fq.size() < 8) fq.push_back(wd);
      else ovf_m = 1'b1;
    end
    if (wr && io && addr[17:0] == 18'h30004) end_m = 1'b1;
    @(posedge clk_in);
    #1;
    chk("ram_data", bus.ram_data_out, rd_q.pop_front());
    chk("tx_valid", {7'd0, bus.tx_valid_out}, {7'd0, fq.size() != 0});
    chk("io_full", {7'd0, bus.io_full_out}, {7'd0, fq.size() == 8});
    chk("overflow", {7'd0, bus.io_overflow_out}, {7'd0, ovf_m});
    chk("sim_end", {7'd0, bus.sim_end_out}, {7'd0, end_m});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ram_data"}, bus.ram_data_out, 8'h00);
    chk({tag, "_tx_valid"}, {7'd0, bus.tx_valid_out}, 8'h00);
    chk({tag, "_io_full"}, {7'd0, bus.io_full_out}, 8'h00);
    chk({tag, "_overflow"}, {7'd0, bus.io_overflow_out}, 8'h00);
    chk({tag, "_sim_end"}, {7'd0, bus.sim_end_out}, 8'h00);
  endtask

  vec_t vecs [19];

  initial begin
    vecs[0]  = '{32'h0000_0010, 8'hA5, 1'b1, 8'h00};
    vecs[1]  = '{32'h0000_0010, 8'h00, 1'b0, 8'hA5};
    vecs[2]  = '{32'h0000_0100, 8'h11, 1'b1, 8'hA5};
    vecs[3]  = '{32'h0000_0101, 8'h22, 1'b1, 8'hA5};
    vecs[4]  = '{32'h0000_0102, 8'h33, 1'b1, 8'hA5};
    vecs[5]  = '{32'h0000_0103, 8'h44, 1'b1, 8'hA5};
    vecs[6]  = '{32'h0000_0100, 8'h00, 1'b0, 8'h11};
    vecs[7]  = '{32'h0000_0101, 8'h00, 1'b0, 8'h22};
    vecs[8]  = '{32'h0000_0102, 8'h00, 1'b0, 8'h33};
    vecs[9]  = '{32'h0000_0103, 8'h00, 1'b0, 8'h44};
    vecs[10] = '{32'h0001_FFFF, 8'h3C, 1'b1, 8'h44};
    vecs[11] = '{32'h0001_FFFF, 8'h00, 1'b0, 8'h3C};
    vecs[12] = '{32'h0003_0010, 8'h99, 1'b1, 8'h3C};
    vecs[13] = '{32'h0003_0004, 8'h00, 1'b0, 8'h00};
    vecs[14] = '{32'h0003_0008, 8'h00, 1'b0, 8'h00};
    vecs[15] = '{32'h0000_0010, 8'h00, 1'b0, 8'hA5};
    vecs[16] = '{32'h0000_0010, 8'h5B, 1'b1, 8'hA5};
    vecs[17] = '{32'h0000_0010, 8'h00, 1'b0, 8'h5B};
    vecs[18] = '{32'h0004_0010, 8'h00, 1'b0, 8'h5B};

    bus.ram_address_in = 32'h0;
    bus.ram_data_in    = 8'h00;
    bus.ram_wr_in      = 1'b0;
    bus.tx_ready_in    = 1'b0;
    rst_in = 1'b1;
    #3 rst_in = 1'b0;
    #1 chk_reset_state("por");
    repeat (2) @(posedge clk_in);
    #1 chk_reset_state("por_clocked");
    rst_in = 1'b1;

    // RAM writes/reads with fixed expected bytes.
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].addr, vecs[i].wd, vecs[i].wr, 1'b0, int'(vecs[i].exp_rd));
      ram_m[vecs[i].addr[16:0]] = vecs[i].wr && vecs[i].addr[17:16] != 2'b11
                                  ? vecs[i].wd : ram_m[vecs[i].addr[16:0]];
    end

    // Full FIFO with simultaneous pop accepts the new byte.
    for (int i = 0; i < 8; i++) step(32'h30000, 8'(i + 1), 1'b1, 1'b0, -1);
    step(32'h30000, 8'h5A, 1'b1, 1'b1, -1);
    for (int i = 0; i < 9; i++) step(32'h00100, 8'h00, 1'b0, 1'b1, -1);

    // Fill, overflow drop, then drain in order.
    for (int i = 0; i < 8; i++) step(32'h30000, 8'(8'hC0 + i), 1'b1, 1'b0, -1);
    step(32'h30000, 8'hEE, 1'b1, 1'b0, -1);
    for (int i = 0; i < 9; i++) step(32'h00101, 8'h00, 1'b0, 1'b1, -1);

    // Halt register and count readback.
    step(32'h30004, 8'h77, 1'b1, 1'b0, -1);
    for (int i = 0; i < 3; i++) step(32'h30000, 8'(8'hD1 + i), 1'b1, 1'b0, -1);
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h03);
    step(32'h30008, 8'h66, 1'b1, 1'b0, -1);
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h03);
    step(32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);

    // Mid-cycle reset with five bytes queued and a push in flight.
    for (int i = 0; i < 2; i++) step(32'h30000, 8'(8'hD4 + i), 1'b1, 1'b0, -1);
    bus.ram_address_in = 32'h30000;
    bus.ram_data_in    = 8'hF0;
    bus.ram_wr_in      = 1'b1;
    #3 rst_in = 1'b0;
    #1 chk_reset_state("async");
    fq.delete();
    ovf_m = 1'b0;
    end_m = 1'b0;
    last_rd = 8'h00;
    @(posedge clk_in);
    #1;
    bus.ram_wr_in = 1'b0;
    rst_in = 1'b1;
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h30000, 8'hE1, 1'b1, 1'b0, -1);
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h01);
    step(32'h00010, 8'h00, 1'b0, 1'b1, 8'h5B);
    step(32'h00103, 8'h00, 1'b0, 1'b1, 8'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_io_responder.md
RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, giving RAM size of 2^ADDR_WIDTH bytes.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8 (power of two), giving TX FIFO entries.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk_in  input  1  rising-edge clock.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 ram_address_in  input  32  byte address from memory controller.
REQ-006 ram_data_in  input  8  write byte from controller.
REQ-007 ram_wr_in  input  1  1 = write, 0 = read.
REQ-008 ram_data_out  output  8  read byte, registered.
REQ-009 io_full_out  output  1  TX FIFO full (controller's hci full input).
REQ-010 tx_data_out  output  8  FIFO head byte.
REQ-011 tx_valid_out  output  1  FIFO non-empty.
REQ-012 tx_ready_in  input  1  downstream sink accepts head byte.
REQ-013 io_overflow_out  output  1  sticky: an IO write was dropped.
REQ-014 sim_end_out  output  1  sticky: halt register written.

Function
REQ-015 SHALL decode an IO access when ram_address_in[17:16] == 2'b11; otherwise it is a RAM access using ram_address_in[ADDR_WIDTH-1:0].
REQ-016 RAM read (ram_wr_in=0, non-IO): ram_data_out SHALL equal mem[addr] one cycle after the address is presented (1-cycle latency, every cycle, no request strobe).
REQ-017 RAM write (ram_wr_in=1, non-IO): mem[addr] SHALL take ram_data_in at the clock edge; ram_data_out SHALL hold its previous value that cycle.
REQ-018 A read of an address written in the preceding cycle SHALL return the newly written byte.
REQ-019 IO write to 0x30000: SHALL push ram_data_in into the TX FIFO when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
REQ-020 IO write to 0x30000 while full without a simultaneous pop: byte SHALL be dropped, FIFO unchanged, io_overflow_out set to 1.
REQ-021 IO write to 0x30004: sim_end_out SHALL be set to 1; byte discarded.
REQ-022 IO read at 0x30004: ram_data_out SHALL return zero-extended FIFO count next cycle; any other IO read returns 8'h00.
REQ-023 Writes to IO addresses other than 0x30000/0x30004: SHALL be ignored.
REQ-024 tx_valid_out SHALL be (count != 0); tx_data_out SHALL be the oldest entry; a pop SHALL occur when tx_valid_out && tx_ready_in.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance, FIFO order preserved.
REQ-026 io_full_out SHALL equal (count == FIFO_DEPTH), derived only from registered state (no combinational path from inputs).
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH or go below 0.
REQ-028 io_overflow_out and sim_end_out SHALL remain set until reset.

Reset
REQ-029 While rst_in=0, regardless of clock: ram_data_out=0, count=0, pointers=0, tx_valid_out=0, io_full_out=0, io_overflow_out=0, sim_end_out=0.
REQ-030 RAM and FIFO storage contents SHALL NOT be reset; a FIFO push in progress when reset asserts SHALL be lost.
REQ-031 First access SHALL be honored on the first rising edge after rst_in deasserts.

Verification
REQ-032 Write 0xA5 to 0x00010, next cycle read 0x00010 -> ram_data_out=0xA5 one cycle after read address presented.
REQ-033 Four writes 0x11,0x22,0x33,0x44 to 0x00100..0x00103, sequential reads -> bytes returned in order, each with 1-cycle latency.
REQ-034 tx_ready_in=0, write 8 bytes to 0x30000 -> io_full_out=1 after 8th edge; 9th write dropped, io_overflow_out=1; then tx_ready_in=1 -> first 8 bytes drained in order, tx_valid_out=0 after.
REQ-035 FIFO full, tx_ready_in=1, IO write 0x5A same cycle -> accepted, count stays 8, 0x5A emerges last.
REQ-036 Write to 0x30004 -> sim_end_out=1; IO read 0x30004 with 3 bytes queued -> ram_data_out=0x03.
REQ-037 Assert rst_in=0 mid-cycle with FIFO holding 5 bytes -> tx_valid_out, io_full_out, count drop to 0 immediately without a clock edge.
